// File: rtl/ble_frame_rx.sv
// ble_frame_rx: sync-byte framed receiver with length/XOR-checksum checks,
// inter-byte timeout, and atomic commit of the verified payload. Rev 1.0
`default_nettype none

module ble_frame_rx #(
  parameter int          NUM_FIELDS     = 10,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100_000,
  parameter int          CNT_W          = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_byte_i,
  input  logic                       rx_valid_i,
  output logic [NUM_FIELDS-1:0][7:0] fields_o,
  output logic                       fields_valid_o,
  output logic                       err_pulse_o,
  output logic [1:0]                 err_code_o,
  output logic [CNT_W-1:0]           frame_ok_cnt_o,
  output logic [CNT_W-1:0]           frame_err_cnt_o
);

  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       LEN_BYTE = 8'(NUM_FIELDS);

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TO  = 2'd3;

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHK     = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [7:0]                  xor_q, xor_d;
  logic [TO_W-1:0]             to_q, to_d;
  logic [NUM_FIELDS-1:0][7:0]  shadow_q;
  logic                        shadow_we;
  logic                        commit;
  logic                        err;
  logic [1:0]                  code;

  logic [NUM_FIELDS-1:0][7:0]  fields_q;
  logic                        fields_valid_q;
  logic                        err_pulse_q;
  logic [1:0]                  err_code_q;
  logic [CNT_W-1:0]            ok_cnt_q;
  logic [CNT_W-1:0]            err_cnt_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    to_d      = '0;
    shadow_we = 1'b0;
    commit    = 1'b0;
    err       = 1'b0;
    code      = 2'd0;

    if (state_q != S_HUNT && !rx_valid_i) begin
      to_d = to_q + TO_W'(1);
    end

    case (state_q)
      S_HUNT: begin
        if (rx_valid_i && rx_byte_i == SYNC_BYTE) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid_i) begin
          if (rx_byte_i == LEN_BYTE) begin
            xor_d   = rx_byte_i;
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end else begin
            err     = 1'b1;
            code    = ERR_LEN;
            state_d = S_HUNT;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid_i) begin
          shadow_we = 1'b1;
          xor_d     = xor_q ^ rx_byte_i;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_CHK;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      S_CHK: begin
        if (rx_valid_i) begin
          if (rx_byte_i == xor_q) begin
            commit = 1'b1;
          end else begin
            err  = 1'b1;
            code = ERR_CHK;
          end
          state_d = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase

    // A byte arriving on the expiry cycle wins, so only an idle cycle times out.
    if (state_q != S_HUNT && !rx_valid_i && to_q == TO_MAX) begin
      err     = 1'b1;
      code    = ERR_TO;
      state_d = S_HUNT;
      to_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HUNT;
      idx_q   <= '0;
      xor_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      to_q    <= to_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shadow_we) begin
      shadow_q[idx_q] <= rx_byte_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fields_q       <= '0;
      fields_valid_q <= 1'b0;
      err_pulse_q    <= 1'b0;
      err_code_q     <= 2'd0;
      ok_cnt_q       <= '0;
      err_cnt_q      <= '0;
    end else begin
      fields_valid_q <= commit;
      err_pulse_q    <= err;
      if (commit) begin
        fields_q <= shadow_q;
        if (ok_cnt_q != '1) begin
          ok_cnt_q <= ok_cnt_q + CNT_W'(1);
        end
      end
      if (err) begin
        err_code_q <= code;
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign fields_o        = fields_q;
  assign fields_valid_o  = fields_valid_q;
  assign err_pulse_o     = err_pulse_q;
  assign err_code_o      = err_code_q;
  assign frame_ok_cnt_o  = ok_cnt_q;
  assign frame_err_cnt_o = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ble_frame_rx.sv
// tb_ble_frame_rx: directed frames with a scoreboard queue of expected
// commit/error events, popped by an independent output monitor. Rev 1.0
`default_nettype none

module tb_ble_frame_rx;

  localparam int NF = 10;
  localparam int TO = 50;
  localparam int CW = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          rx_byte = 8'h00;
  logic                rx_valid = 1'b0;
  logic [NF-1:0][7:0]  fields;
  logic                fields_valid;
  logic                err_pulse;
  logic [1:0]          err_code;
  logic [CW-1:0]       ok_cnt;
  logic [CW-1:0]       err_cnt;

  ble_frame_rx #(
    .NUM_FIELDS     (NF),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_byte_i       (rx_byte),
    .rx_valid_i      (rx_valid),
    .fields_o        (fields),
    .fields_valid_o  (fields_valid),
    .err_pulse_o     (err_pulse),
    .err_code_o      (err_code),
    .frame_ok_cnt_o  (ok_cnt),
    .frame_err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 kind;   // 0 = commit, 1 = error
    logic [1:0]         code;
    logic [CW-1:0]      ok;
    logic [CW-1:0]      err;
    logic [NF-1:0][7:0] f;
    int                 cyc;    // -1 = any cycle
  } exp_t;

  exp_t               sb[$];
  int                 n_checks = 0;
  int                 n_err = 0;
  int                 cyc = 0;
  int                 last_cyc = 0;
  logic [NF-1:0][7:0] pl_good;
  logic [NF-1:0][7:0] pl_a5;
  logic [NF-1:0][7:0] pl_zero;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [1:0] code, input logic [CW-1:0] ok,
                      input logic [CW-1:0] err, input logic [NF-1:0][7:0] f, input int c);
    exp_t e;
    e.kind = kind; e.code = code; e.ok = ok; e.err = err; e.f = f; e.cyc = c;
    sb.push_back(e);
  endtask

  // Called on a negedge; returns on the next negedge so calls chain back-to-back.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_frame(input logic [NF-1:0][7:0] pl, input logic [7:0] chk, input int gap0);
    send_byte(8'hA5);
    send_byte(8'(NF));
    for (int i = 0; i < NF; i++) begin
      if (i == 0) idle(gap0);
      send_byte(pl[i]);
    end
    send_byte(chk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 80'(sb.size()), 80'd0);
  endtask

  // Monitor: pops one expected event per output pulse.
  always @(posedge clk) begin
    #1;
    if (fields_valid || err_pulse) begin
      check("exclusive_pulses", 80'(fields_valid & err_pulse), 80'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b code=%0d expected no pulse (t=%0t)",
                 fields_valid, err_pulse, err_code, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_kind", 80'(err_pulse ? 1 : 0), 80'(e.kind));
        check("fields", 80'(fields), 80'(e.f));
        check("err_code", 80'(err_code), 80'(e.code));
        check("ok_cnt", 80'(ok_cnt), 80'(e.ok));
        check("err_cnt", 80'(err_cnt), 80'(e.err));
        if (e.cyc >= 0) check("event_cycle", 80'(cyc), 80'(e.cyc));
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NF; i++) pl_good[i] = 8'(i + 1);
    pl_a5 = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'hA5};
    pl_zero = '0;

    @(negedge clk);
    idle(3);
    rst = 1'b0;
    check("reset_fields", 80'(fields), 80'd0);
    check("reset_valid", 80'(fields_valid), 80'd0);
    check("reset_errp", 80'(err_pulse), 80'd0);
    check("reset_code", 80'(err_code), 80'd0);
    check("reset_ok", 80'(ok_cnt), 80'd0);
    check("reset_errc", 80'(err_cnt), 80'd0);

    // Good frame, then the same frame with a wrong checksum
    push(0, 2'd0, 2'd1, 2'd0, pl_good, -1);
    send_frame(pl_good, 8'h01, 0);
    push(1, 2'd2, 2'd1, 2'd1, pl_good, -1);
    send_frame(pl_good, 8'h00, 0);
    drain("drain_g1");

    // Junk, bad length, then resync on a good frame
    pulse_rst();
    send_byte(8'h3C);
    send_byte(8'h55);
    send_byte(8'hA5);
    push(1, 2'd1, 2'd0, 2'd1, pl_zero, -1);
    send_byte(8'h07);
    push(0, 2'd1, 2'd1, 2'd1, pl_good, -1);
    send_frame(pl_good, 8'h01, 0);
    drain("drain_g2");

    // Timeout 50 cycles after the last byte, recovery, boundary frames, saturation
    pulse_rst();
    send_byte(8'hA5);
    send_byte(8'h0A);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    push(1, 2'd3, 2'd0, 2'd1, pl_zero, last_cyc + TO);
    idle(60);
    push(0, 2'd3, 2'd1, 2'd1, pl_good, -1);
    send_frame(pl_good, 8'h01, 0);
    push(0, 2'd3, 2'd2, 2'd1, pl_good, -1);
    send_frame(pl_good, 8'h01, TO - 1);
    push(0, 2'd3, 2'd3, 2'd1, pl_a5, -1);
    send_frame(pl_a5, 8'h27, 0);
    push(0, 2'd3, 2'd3, 2'd1, pl_good, -1);
    push(0, 2'd3, 2'd3, 2'd1, pl_a5, -1);
    send_frame(pl_good, 8'h01, 0);
    send_frame(pl_a5, 8'h27, 0);
    drain("drain_g3");
    check("err_code_hold", 80'(err_code), 80'd3);

    // Reset mid-frame; the tail of the aborted frame must be ignored
    send_byte(8'hA5);
    send_byte(8'h0A);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    pulse_rst();
    check("midrst_fields", 80'(fields), 80'd0);
    check("midrst_valid", 80'(fields_valid), 80'd0);
    check("midrst_errp", 80'(err_pulse), 80'd0);
    check("midrst_code", 80'(err_code), 80'd0);
    check("midrst_ok", 80'(ok_cnt), 80'd0);
    check("midrst_errc", 80'(err_cnt), 80'd0);
    for (int i = 4; i <= NF; i++) send_byte(8'(i));
    send_byte(8'h01);
    idle(TO + 10);
    drain("drain_g4");
    check("tail_ok", 80'(ok_cnt), 80'd0);
    check("tail_errc", 80'(err_cnt), 80'd0);
    check("tail_fields", 80'(fields), 80'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
